// File: rtl/dp_pkg.sv
// Shared codes and FSM states for the multi-cycle datapath.
// Optional feature macro: R0_ZERO_EN (hard-wired zero register).
package dp_pkg;

    localparam int DP_DATA_W = 32;
    localparam int DP_REG_AW = 5;
    localparam int DP_MEM_AW = 6;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_LOADI = 2'b11
    } op_kind_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_NOR = 3'b011,
        ALU_ADD = 3'b100,
        ALU_SUB = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EX   = 3'd2,
        S_MA   = 3'd3,
        S_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: F = A op B with zero and signed-overflow flags.
// Shift amount is the low log2(DATA_W) bits of A; overflow only for ADD/SUB.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] f_o,
    output logic              zf_o,
    output logic              of_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              a_s;
    logic              b_s;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign a_s  = a_i[DATA_W-1];
    assign b_s  = b_i[DATA_W-1];

    always_comb begin
        f_o  = '0;
        of_o = 1'b0;
        unique case (op_i)
            ALU_AND: f_o = a_i & b_i;
            ALU_OR:  f_o = a_i | b_i;
            ALU_XOR: f_o = a_i ^ b_i;
            ALU_NOR: f_o = ~(a_i | b_i);
            ALU_ADD: begin
                f_o  = sum;
                of_o = (a_s == b_s) && (sum[DATA_W-1] != a_s);
            end
            ALU_SUB: begin
                f_o  = diff;
                of_o = (a_s != b_s) && (diff[DATA_W-1] != a_s);
            end
            ALU_SLT: f_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLL: f_o = b_i << a_i[SH_W-1:0];
            default: f_o = '0;
        endcase
    end

    assign zf_o = (f_o == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FSM-sequenced regfile read, ALU, RAM access, write-back.
// Macro R0_ZERO_EN makes REG[0] read as zero and ignore writes.
module mc_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int REG_AW = DP_REG_AW,
    parameter int MEM_AW = DP_MEM_AW
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op_kind,
    input  logic [2:0]        alu_op,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ZF,
    output logic              OF
);

    localparam int NREG = 2 ** REG_AW;
    localparam int NMEM = 2 ** MEM_AW;

    state_e            state_q;
    state_e            state_d;
    op_kind_e          kind_q;
    alu_op_e           aop_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] f_q;
    logic              zf_q;
    logic              of_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] mem_q  [NMEM];

    logic              accept;
    logic              reg_we;
    logic              mem_we;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;
    logic [DATA_W-1:0] alu_f;
    logic              alu_zf;
    logic              alu_of;
    logic [MEM_AW-1:0] maddr;

    assign accept = req_valid & req_ready;
    assign maddr  = f_q[MEM_AW-1:0];

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (aop_q),
        .f_o  (alu_f),
        .zf_o (alu_zf),
        .of_o (alu_of)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op_kind == OP_LOADI) ? S_WB : S_RD;
                end
            end
            S_RD: state_d = S_EX;
            S_EX: state_d = (kind_q == OP_ALU) ? S_WB : S_MA;
            S_MA: state_d = (kind_q == OP_STORE) ? S_IDLE : S_WB;
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write enables are gated by Reset so an abort never commits state.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        done      = (state_q == S_WB) ||
                    ((state_q == S_MA) && (kind_q == OP_STORE));
        mem_we    = (state_q == S_MA) && (kind_q == OP_STORE) && !Reset;
        reg_we    = (state_q == S_WB) && !Reset;
`ifdef R0_ZERO_EN
        if (rd_q == '0) begin
            reg_we = 1'b0;
        end
`endif
        unique case (kind_q)
            OP_LOAD:  wb_data = rdata_q;
            OP_LOADI: wb_data = imm_q;
            default:  wb_data = f_q;
        endcase
    end

    always_comb begin
        a_rd = regs_q[rs_q];
        b_rd = regs_q[rt_q];
`ifdef R0_ZERO_EN
        if (rs_q == '0) begin
            a_rd = '0;
        end
        if (rt_q == '0) begin
            b_rd = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            kind_q   <= OP_ALU;
            aop_q    <= ALU_AND;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
            result_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                kind_q <= op_kind_e'(op_kind);
                aop_q  <= alu_op_e'(alu_op);
                rs_q   <= rs;
                rt_q   <= rt;
                rd_q   <= rd;
                imm_q  <= imm;
            end
            if (state_q == S_RD) begin
                a_q <= a_rd;
                b_q <= b_rd;
            end
            if (state_q == S_EX) begin
                f_q <= alu_f;
                if (kind_q != OP_LOAD) begin
                    zf_q <= alu_zf;
                    of_q <= alu_of;
                end
            end
            if (reg_we) begin
                regs_q[rd_q] <= wb_data;
            end
            if (done) begin
                result_q <= wb_data;
            end
        end
    end

    // RAM is never cleared; read is registered so LOAD data lands in WB.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[maddr] <= b_q;
        end
        rdata_q <= mem_q[maddr];
    end

    assign result = result_q;
    assign ZF     = zf_q;
    assign OF     = of_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed table-driven bench for mc_datapath plus reset-abort sequence.
// Expectations adapt when R0_ZERO_EN is defined.
module tb_mc_datapath;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  aop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] res;
        int          lat;
        bit          fl;
        bit          zf;
        bit          of;
    } vec_t;

    localparam logic [1:0] K_ALU = 2'b00;
    localparam logic [1:0] K_LD  = 2'b01;
    localparam logic [1:0] K_ST  = 2'b10;
    localparam logic [1:0] K_LI  = 2'b11;

`ifdef R0_ZERO_EN
    localparam logic [31:0] EXP_R0ADD = 32'hFFFF_0000;
    localparam logic [31:0] EXP_DBL   = 32'h0000_0000;
    localparam bit          EXP_DBLZ  = 1'b1;
`else
    localparam logic [31:0] EXP_R0ADD = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_DBL   = 32'h0000_2468;
    localparam bit          EXP_DBLZ  = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op_kind;
    logic [2:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        done;
    logic [31:0] result;
    logic        ZF;
    logic        OF;

    int checks;
    int errors;

    vec_t vt[$];
    vec_t vp[$];

    mc_datapath dut (
        .clk       (clk),
        .Reset     (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_kind   (op_kind),
        .alu_op    (alu_op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .done      (done),
        .result    (result),
        .ZF        (ZF),
        .OF        (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, input int id, output int n);
        @(negedge clk);
        chk("ready", id, {31'd0, req_ready}, 32'd1);
        op_kind   = v.kind;
        alu_op    = v.aop;
        rs        = v.rs;
        rt        = v.rt;
        rd        = v.rd;
        imm       = v.imm;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        imm       = $urandom;
        rd        = 5'($urandom);
        rs        = 5'($urandom);
        rt        = 5'($urandom);
        alu_op    = 3'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", id, n, v.lat);
    endtask

    task automatic run(input vec_t v, input int id);
        int n;
        issue(v, id, n);
        @(posedge clk);
        #1;
        chk("result", id, result, v.res);
        chk("pulse", id, {31'd0, done}, 32'd0);
        if (v.fl) begin
            chk("ZF", id, {31'd0, ZF}, {31'd0, v.zf});
            chk("OF", id, {31'd0, OF}, {31'd0, v.of});
        end
    endtask

    initial begin
        int n;
        vec_t st;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        op_kind   = '0;
        alu_op    = '0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        imm       = '0;

        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_FFFF, 32'h0000_FFFF, 1, 0, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_0000, 32'hFFFF_0000, 1, 0, 0, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd0, 5'd1, 5'd2, 32'h0, EXP_R0ADD, 3, 1, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd4, 32'h0000_0001, 32'h0000_0001, 1, 0, 0, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd3, 5'd4, 5'd5, 32'h0, 32'h8000_0000, 3, 1, 0, 1});
        vt.push_back('{K_ALU, 3'd5, 5'd3, 5'd3, 5'd6, 32'h0, 32'h0000_0000, 3, 1, 1, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 0});
        vt.push_back('{K_ALU, 3'd6, 5'd7, 5'd4, 5'd8, 32'h0, 32'h0000_0001, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd6, 5'd4, 5'd7, 5'd9, 32'h0, 32'h0000_0000, 3, 1, 1, 0});
        vt.push_back('{K_ALU, 3'd5, 5'd5, 5'd4, 5'd10, 32'h0, 32'h7FFF_FFFF, 3, 1, 0, 1});
        vt.push_back('{K_ALU, 3'd0, 5'd1, 5'd7, 5'd11, 32'h0, 32'hFFFF_0000, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd1, 5'd1, 5'd4, 5'd12, 32'h0, 32'hFFFF_0001, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd2, 5'd7, 5'd1, 5'd13, 32'h0, 32'h0000_FFFF, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd3, 5'd1, 5'd4, 5'd14, 32'h0, 32'h0000_FFFE, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd7, 5'd4, 5'd1, 5'd15, 32'h0, 32'hFFFE_0000, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd7, 5'd7, 5'd4, 5'd16, 32'h0, 32'h8000_0000, 3, 1, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd20, 32'h0, 32'h0000_0000, 1, 1, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd21, 32'h5, 32'h0000_0005, 1, 0, 0, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd21, 5'd21, 5'd21, 32'h0, 32'h0000_000A, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd21, 5'd4, 5'd21, 32'h0, 32'h0000_000B, 3, 1, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd22, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 0, 0, 0});
        vt.push_back('{K_ST, 3'd4, 5'd7, 5'd22, 5'd0, 32'h0, 32'hAAAA_AAA9, 3, 1, 0, 0});
        vt.push_back('{K_ALU, 3'd5, 5'd3, 5'd3, 5'd17, 32'h0, 32'h0000_0000, 3, 1, 1, 0});
        vt.push_back('{K_LD, 3'd4, 5'd7, 5'd22, 5'd23, 32'h0, 32'hAAAA_AAAA, 4, 1, 1, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd23, 5'd4, 5'd24, 32'h0, 32'hAAAA_AAAB, 3, 1, 0, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_1234, 32'h0000_1234, 1, 0, 0, 0});
        vt.push_back('{K_ALU, 3'd4, 5'd0, 5'd0, 5'd3, 32'h0, EXP_DBL, 3, 1, EXP_DBLZ, 0});
        vt.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd25, 32'h5555_556A, 32'h5555_556A, 1, 0, 0, 0});

        vp.push_back('{K_ALU, 3'd4, 5'd7, 5'd25, 5'd1, 32'h0, 32'h0000_0000, 3, 1, 1, 0});
        vp.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0});
        vp.push_back('{K_LI, 3'd0, 5'd0, 5'd0, 5'd2, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 0, 0, 0});
        vp.push_back('{K_LD, 3'd4, 5'd1, 5'd2, 5'd3, 32'h0, 32'hAAAA_AAAA, 4, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 0, {31'd0, req_ready}, 32'd1);
        chk("rst_done", 0, {31'd0, done}, 32'd0);
        chk("rst_result", 0, result, 32'd0);
        chk("rst_flags", 0, {30'd0, ZF, OF}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            run(vt[i], i);
        end

        // STORE to word 0x29 aborted by reset during its MA cycle
        st = '{K_ST, 3'd4, 5'd7, 5'd25, 5'd0, 32'h0, 32'h0, 3, 0, 0, 0};
        issue(st, 100, n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", 100, {31'd0, req_ready}, 32'd1);
        chk("abort_done", 100, {31'd0, done}, 32'd0);
        chk("abort_result", 100, result, 32'd0);
        chk("abort_flags", 100, {30'd0, ZF, OF}, 32'd0);

        for (int i = 0; i < vp.size(); i++) begin
            run(vp[i], 200 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
